// File: rtl/uart_rx_fifo.sv
// Receive-side show-ahead FIFO behind the UART receiver, with per-entry frame
// status, sticky overrun flag and saturating error/overrun counters.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  par_err_in,
    input  logic                  stp_err_in,
    input  logic                  drop_err_en,
    input  logic                  rd_ready,
    input  logic                  clr_stat,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            rd_status,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt,
    output logic [CNT_WIDTH-1:0]  ovr_cnt
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned EW = DATA_WIDTH + 2;

    logic [EW-1:0]         r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_rd_valid;
    logic                  r_full;
    logic [EW-1:0]         r_head;
    logic                  r_overrun;
    logic [CNT_WIDTH-1:0]  r_par_cnt;
    logic [CNT_WIDTH-1:0]  r_stp_cnt;
    logic [CNT_WIDTH-1:0]  r_ovr_cnt;

    logic                  w_err;
    logic                  w_evt;
    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_wr_en;
    logic                  w_drop;
    logic [EW-1:0]         w_entry;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [EW-1:0]         w_head_nxt;

    // Saturating increment; a same-cycle event overrides the clear.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] res;
        res = cur;
        if (clr) begin
            res = inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (cur != '1)) begin
            res = cur + CNT_WIDTH'(1);
        end
        return res;
    endfunction

    always_comb begin
        w_err        = par_err_in | stp_err_in;
        w_evt        = data_valid | w_err;
        w_push_req   = w_evt & ~(drop_err_en & w_err);
        w_pop        = r_rd_valid & rd_ready;
        w_wr_en      = w_push_req & (~r_full | w_pop);
        w_drop       = w_push_req & r_full & ~w_pop;
        w_entry      = {stp_err_in, par_err_in, P_DATA};
        w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(w_pop);
        w_count_nxt  = r_count;
        if (w_wr_en && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_en && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
        // New entry becomes head when the FIFO is (or becomes) empty this cycle.
        w_head_nxt = r_head;
        if (w_wr_en && (r_count == CW'(w_pop))) begin
            w_head_nxt = w_entry;
        end else if (w_count_nxt != '0) begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_full     <= 1'b0;
            r_head     <= '0;
            r_overrun  <= 1'b0;
            r_par_cnt  <= '0;
            r_stp_cnt  <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_head     <= w_head_nxt;
            r_overrun  <= w_drop | (r_overrun & ~clr_stat);
            r_par_cnt  <= cnt_next(r_par_cnt, par_err_in, clr_stat);
            r_stp_cnt  <= cnt_next(r_stp_cnt, stp_err_in, clr_stat);
            r_ovr_cnt  <= cnt_next(r_ovr_cnt, w_drop, clr_stat);
        end
    end

    assign rd_data     = r_head[DATA_WIDTH-1:0];
    assign rd_status   = r_head[EW-1:DATA_WIDTH];
    assign rd_valid    = r_rd_valid;
    assign fifo_count  = r_count;
    assign full        = r_full;
    assign overrun     = r_overrun;
    assign par_err_cnt = r_par_cnt;
    assign stp_err_cnt = r_stp_cnt;
    assign ovr_cnt     = r_ovr_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus hand-computed literal expectations at key points.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       data_valid = 1'b0;
    logic       par_err_in = 1'b0;
    logic       stp_err_in = 1'b0;
    logic       drop_err_en = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_stat = 1'b0;
    logic [7:0] rd_data;
    logic [1:0] rd_status;
    logic       rd_valid;
    logic [3:0] fifo_count;
    logic       full;
    logic       overrun;
    logic [7:0] par_err_cnt;
    logic [7:0] stp_err_cnt;
    logic [7:0] ovr_cnt;

    uart_rx_fifo dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err_in(par_err_in), .stp_err_in(stp_err_in),
        .drop_err_en(drop_err_en), .rd_ready(rd_ready), .clr_stat(clr_stat),
        .rd_data(rd_data), .rd_status(rd_status), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .full(full), .overrun(overrun),
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt), .ovr_cnt(ovr_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model
    logic [9:0] exp_q[$];
    logic [7:0] pop_hist[$];
    bit         m_ovr = 1'b0;
    int         m_par = 0;
    int         m_stp = 0;
    int         m_ovc = 0;

    function automatic int sat_inc(input int cur, input bit inc, input bit clr);
        if (clr) return inc ? 1 : 0;
        if (inc) return (cur >= 255) ? 255 : cur + 1;
        return cur;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exp_q.delete();
            m_ovr = 1'b0;
            m_par = 0;
            m_stp = 0;
            m_ovc = 0;
        end else begin
            bit err, store, pop, drop;
            err   = par_err_in | stp_err_in;
            store = (data_valid | err) & ~(drop_err_en & err);
            pop   = (exp_q.size() != 0) && rd_ready;
            drop  = store && (exp_q.size() == DEPTH) && !pop;
            if (pop) pop_hist.push_back(exp_q.pop_front() & 10'h0FF);
            if (store && !drop) exp_q.push_back({stp_err_in, par_err_in, P_DATA});
            m_ovr = drop | (m_ovr & ~clr_stat);
            m_par = sat_inc(m_par, par_err_in, clr_stat);
            m_stp = sat_inc(m_stp, stp_err_in, clr_stat);
            m_ovc = sat_inc(m_ovc, drop, clr_stat);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en && RST) begin
            chk("m_rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
            chk("m_count", 32'(fifo_count), 32'(exp_q.size()));
            chk("m_full", 32'(full), 32'(exp_q.size() == DEPTH));
            chk("m_overrun", 32'(overrun), 32'(m_ovr));
            chk("m_par_cnt", 32'(par_err_cnt), 32'(m_par));
            chk("m_stp_cnt", 32'(stp_err_cnt), 32'(m_stp));
            chk("m_ovr_cnt", 32'(ovr_cnt), 32'(m_ovc));
            if (exp_q.size() != 0) begin
                chk("m_rd_data", 32'(rd_data), 32'(exp_q[0][7:0]));
                chk("m_rd_status", 32'(rd_status), 32'(exp_q[0][9:8]));
            end
        end
    end

    // Apply one cycle of inputs, return at the following falling edge.
    task automatic drive(input bit dv, input bit pe, input bit se, input bit drop,
                         input bit rdy, input bit clr, input logic [7:0] d);
        data_valid  = dv;
        par_err_in  = pe;
        stp_err_in  = se;
        drop_err_en = drop;
        rd_ready    = rdy;
        clr_stat    = clr;
        P_DATA      = d;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_count"}, 32'(fifo_count), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_par"}, 32'(par_err_cnt), 0);
        chk({tag, "_stp"}, 32'(stp_err_cnt), 0);
        chk({tag, "_ovc"}, 32'(ovr_cnt), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_all_zero("rst");
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_status", 32'(rd_status), 0);
        #10 RST = 1'b1;
        @(negedge CLK);
        chk_en = 1'b1;

        // Three good frames then ordered read-out
        drive(1, 0, 0, 0, 0, 0, 8'h11);
        drive(1, 0, 0, 0, 0, 0, 8'h22);
        drive(1, 0, 0, 0, 0, 0, 8'h33);
        idle();
        chk("t1_count", 32'(fifo_count), 3);
        chk("t1_valid", 32'(rd_valid), 1);
        chk("t1_head", 32'(rd_data), 32'h11);
        chk("t1_status", 32'(rd_status), 0);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t1_pop1", 32'(rd_data), 32'h22);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t1_pop2", 32'(rd_data), 32'h33);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t1_empty_valid", 32'(rd_valid), 0);
        chk("t1_empty_count", 32'(fifo_count), 0);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t1_rdy_empty", 32'(fifo_count), 0);

        // Parity error stored, stop error dropped
        drive(0, 1, 0, 0, 0, 0, 8'hA5);
        chk("t2_data", 32'(rd_data), 32'hA5);
        chk("t2_status", 32'(rd_status), 1);
        chk("t2_par", 32'(par_err_cnt), 1);
        drive(0, 0, 1, 1, 0, 0, 8'h3C);
        chk("t2_stp", 32'(stp_err_cnt), 1);
        chk("t2_count", 32'(fifo_count), 1);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t2_drained", 32'(fifo_count), 0);

        // Full, overrun, push+pop while full
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 0, 8'(i));
        drive(1, 0, 0, 0, 0, 0, 8'hFF);
        chk("t3_full", 32'(full), 1);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_ovr_cnt", 32'(ovr_cnt), 1);
        chk("t3_head", 32'(rd_data), 0);
        drive(1, 0, 0, 0, 1, 0, 8'hEE);
        chk("t3_pp_count", 32'(fifo_count), 8);
        chk("t3_pp_head", 32'(rd_data), 1);
        chk("t3_pp_ovr", 32'(ovr_cnt), 1);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t3_drained", 32'(fifo_count), 0);

        // Pointer wrap with random consumer
        begin
            int sent = 0;
            int guard = 0;
            pop_hist.delete();
            while ((sent < 20 || exp_q.size() != 0) && guard < 400) begin
                bit rdy;
                rdy = 1'($urandom_range(0, 1));
                if (sent < 20 && exp_q.size() < DEPTH) begin
                    drive(1, 0, 0, 0, rdy, 0, 8'(sent));
                    sent++;
                end else begin
                    drive(0, 0, 0, 0, rdy, 0, 8'h00);
                end
                guard++;
            end
            chk("t4_no_timeout", 32'(guard >= 400), 0);
            chk("t4_pops", 32'(pop_hist.size()), 20);
            for (int i = 0; i < 20 && i < pop_hist.size(); i++)
                chk("t4_order", 32'(pop_hist[i]), 32'(i));
            chk("t4_ovr_cnt", 32'(ovr_cnt), 1);
        end

        // Counter saturation and clear interplay
        for (int i = 0; i < 300; i++) drive(0, 1, 0, 1, 0, 0, 8'h00);
        chk("t5_sat", 32'(par_err_cnt), 32'hFF);
        drive(0, 1, 0, 1, 0, 1, 8'h00);
        chk("t5_clr_evt", 32'(par_err_cnt), 1);
        chk("t5_clr_ovr", 32'(overrun), 0);
        drive(0, 0, 0, 0, 0, 1, 8'h00);
        chk("t5_clr_par", 32'(par_err_cnt), 0);
        chk("t5_clr_ovr2", 32'(overrun), 0);
        chk("t5_clr_ovc", 32'(ovr_cnt), 0);

        // Overrun coinciding with clear: event wins
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 0, 8'h40 + 8'(i));
        drive(1, 0, 0, 0, 0, 1, 8'h99);
        chk("t6_ovr_clr", 32'(overrun), 1);
        chk("t6_ovc_clr", 32'(ovr_cnt), 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 8'h00);
        drive(0, 1, 0, 1, 0, 0, 8'h00);
        chk("t6_count5", 32'(fifo_count), 5);
        chk("t6_head", 32'(rd_data), 32'h43);

        // Asynchronous reset mid-cycle
        data_valid = 1'b0; par_err_in = 1'b0; rd_ready = 1'b1; drop_err_en = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge CLK);
        #2 RST = 1'b1;
        rd_ready = 1'b0;
        @(negedge CLK);
        drive(1, 0, 0, 0, 0, 0, 8'h5A);
        chk("t7_head", 32'(rd_data), 32'h5A);
        chk("t7_count", 32'(fifo_count), 1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
